// File: rtl/gpreg_xfer_seq.sv
// Register-transfer sequencer: drives one source onto the MAIN bus, strobes LOAD on the destination, then holds.
// Optional feature: define GPREG_XFER_EXT_EN to let MODE=1 select the external MAIN bus driver.
module gpreg_xfer_seq #(
    parameter int LOAD_HOLD = 1
) (
    input  logic       CLK,
    input  logic       RST_bar,
    input  logic       REQ,
    input  logic [1:0] SRC,
    input  logic [1:0] DST,
    input  logic       MODE,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] ASSERT_MAIN_bar,
    output logic       ASSERT_EXT_bar,
    output logic [3:0] LOAD
);

    typedef enum logic [1:0] {IDLE, DRIVE, STROBE, HOLD} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(LOAD_HOLD - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [1:0] src_q, dst_q;
    logic       accept;
    logic [1:0] sel_src, sel_dst;
    logic       sel_ext;
    logic       busy_nx, done_nx, ext_nx;
    logic [3:0] main_nx, load_nx;

    assign accept  = (state == IDLE) && REQ;
    // On the accepting edge the capture registers are not loaded yet, so decode from the live inputs.
    assign sel_src = accept ? SRC : src_q;
    assign sel_dst = accept ? DST : dst_q;

`ifdef GPREG_XFER_EXT_EN
    logic mode_q;
    assign sel_ext = accept ? MODE : mode_q;

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar)    mode_q <= 1'b0;
        else if (accept) mode_q <= MODE;
    end
`else
    logic unused_mode;
    assign unused_mode = MODE;
    assign sel_ext     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state <= IDLE;
            cnt   <= 4'd0;
            src_q <= 2'd0;
            dst_q <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                src_q <= SRC;
                dst_q <= DST;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE:   if (REQ) state_nx = DRIVE;
            DRIVE: begin
                state_nx = STROBE;
                cnt_nx   = 4'd0;
            end
            STROBE: begin
                if (cnt == HOLD_LAST) state_nx = HOLD;
                else                  cnt_nx   = cnt + 4'd1;
            end
            HOLD:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so nothing combinational reaches a port.
    always_comb begin
        busy_nx = (state_nx != IDLE);
        done_nx = (state == HOLD);
        main_nx = 4'hF;
        ext_nx  = 1'b1;
        load_nx = 4'h0;
        if (busy_nx) begin
            if (sel_ext) ext_nx           = 1'b0;
            else         main_nx[sel_src] = 1'b0;
        end
        if (state_nx == STROBE) load_nx[sel_dst] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            BUSY            <= 1'b0;
            DONE            <= 1'b0;
            ASSERT_MAIN_bar <= 4'hF;
            ASSERT_EXT_bar  <= 1'b1;
            LOAD            <= 4'h0;
        end else begin
            BUSY            <= busy_nx;
            DONE            <= done_nx;
            ASSERT_MAIN_bar <= main_nx;
            ASSERT_EXT_bar  <= ext_nx;
            LOAD            <= load_nx;
        end
    end

endmodule

// File: tb/tb_gpreg_xfer_seq.sv
// Directed bench for gpreg_xfer_seq: one instance with LOAD_HOLD=1, one with LOAD_HOLD=3.
module tb_gpreg_xfer_seq;

    logic       CLK = 1'b0;
    logic       RST_bar = 1'b0;
    logic       req1 = 1'b0, req3 = 1'b0;
    logic [1:0] SRC = 2'd0, DST = 2'd0;
    logic       MODE = 1'b0;

    logic       busy1, done1, ext1, busy3, done3, ext3;
    logic [3:0] main1, load1, main3, load3;

    int tests = 0;
    int fails = 0;
    logic excl_bad = 1'b0;

    // {BUSY, DONE, ASSERT_MAIN_bar, ASSERT_EXT_bar, LOAD}
    logic [10:0] o1, o3;
    assign o1 = {busy1, done1, main1, ext1, load1};
    assign o3 = {busy3, done3, main3, ext3, load3};

    always #5 CLK = ~CLK;

    gpreg_xfer_seq #(.LOAD_HOLD(1)) dut1 (
        .CLK(CLK), .RST_bar(RST_bar), .REQ(req1), .SRC(SRC), .DST(DST), .MODE(MODE),
        .BUSY(busy1), .DONE(done1), .ASSERT_MAIN_bar(main1), .ASSERT_EXT_bar(ext1), .LOAD(load1)
    );

    gpreg_xfer_seq #(.LOAD_HOLD(3)) dut3 (
        .CLK(CLK), .RST_bar(RST_bar), .REQ(req3), .SRC(SRC), .DST(DST), .MODE(MODE),
        .BUSY(busy3), .DONE(done3), .ASSERT_MAIN_bar(main3), .ASSERT_EXT_bar(ext3), .LOAD(load3)
    );

    // Bus exclusivity watcher, sampled mid-cycle on both instances.
    always @(negedge CLK) begin
        if ($countones(~main1) > 1 || (!ext1 && main1 != 4'hF) || $countones(load1) > 1 ||
            (load1 != 4'h0 && ext1 && main1 == 4'hF))
            excl_bad <= 1'b1;
        if ($countones(~main3) > 1 || (!ext3 && main3 != 4'hF) || $countones(load3) > 1 ||
            (load3 != 4'h0 && ext3 && main3 == 4'hF))
            excl_bad <= 1'b1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_bar = 1'b0;
        #12;
        tests++;
        if (o1 !== 11'b0_0_1111_1_0000) begin
            fails++; $display("FAIL reset_dut1 got %b want %b", o1, 11'b0_0_1111_1_0000);
        end
        tests++;
        if (o3 !== 11'b0_0_1111_1_0000) begin
            fails++; $display("FAIL reset_dut3 got %b want %b", o3, 11'b0_0_1111_1_0000);
        end
        @(negedge CLK);
        RST_bar = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        req1 = 1'b1; SRC = 2'd2; DST = 2'd1; MODE = 1'b0;
        tick();
        req1 = 1'b0;
        tests++;
        if (o1 !== 11'b1_0_1011_1_0000) begin
            fails++; $display("FAIL basic_drive got %b want %b", o1, 11'b1_0_1011_1_0000);
        end
        tick();
        tests++;
        if (o1 !== 11'b1_0_1011_1_0010) begin
            fails++; $display("FAIL basic_strobe got %b want %b", o1, 11'b1_0_1011_1_0010);
        end
        tick();
        tests++;
        if (o1 !== 11'b1_0_1011_1_0000) begin
            fails++; $display("FAIL basic_hold got %b want %b", o1, 11'b1_0_1011_1_0000);
        end
        tick();
        tests++;
        if (o1 !== 11'b0_1_1111_1_0000) begin
            fails++; $display("FAIL basic_done got %b want %b", o1, 11'b0_1_1111_1_0000);
        end
        tick();
        tests++;
        if (o1 !== 11'b0_0_1111_1_0000) begin
            fails++; $display("FAIL basic_idle got %b want %b", o1, 11'b0_0_1111_1_0000);
        end
    endtask

    task automatic test_hold3();
        int load_cyc = 0, busy_cyc = 0, done_cyc = 0, main_bad = 0;
        req3 = 1'b1; SRC = 2'd0; DST = 2'd3; MODE = 1'b0;
        tick();
        req3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (load3 == 4'b1000) load_cyc++;
            if (busy3) begin
                busy_cyc++;
                if (main3 != 4'b1110) main_bad++;
            end
            if (done3) done_cyc++;
            tick();
        end
        tests++;
        if (load_cyc != 3) begin fails++; $display("FAIL hold3_load_cycles got %0d want 3", load_cyc); end
        tests++;
        if (busy_cyc != 5) begin fails++; $display("FAIL hold3_busy_cycles got %0d want 5", busy_cyc); end
        tests++;
        if (done_cyc != 1) begin fails++; $display("FAIL hold3_done_cycles got %0d want 1", done_cyc); end
        tests++;
        if (main_bad != 0) begin fails++; $display("FAIL hold3_main_bus got %0d bad cycles want 0", main_bad); end
    endtask

    task automatic test_back_to_back();
        req1 = 1'b1; SRC = 2'd0; DST = 2'd1; MODE = 1'b0;
        tick();
        SRC = 2'd1; DST = 2'd0;
        tests++;
        if (o1 !== 11'b1_0_1110_1_0000) begin
            fails++; $display("FAIL b2b_drive0 got %b want %b", o1, 11'b1_0_1110_1_0000);
        end
        tick();
        tests++;
        if (o1 !== 11'b1_0_1110_1_0010) begin
            fails++; $display("FAIL b2b_strobe0 got %b want %b", o1, 11'b1_0_1110_1_0010);
        end
        tick();
        tick();
        tests++;
        if (o1 !== 11'b0_1_1111_1_0000) begin
            fails++; $display("FAIL b2b_done0 got %b want %b", o1, 11'b0_1_1111_1_0000);
        end
        tick();
        tests++;
        if (o1 !== 11'b1_0_1101_1_0000) begin
            fails++; $display("FAIL b2b_drive1 got %b want %b", o1, 11'b1_0_1101_1_0000);
        end
        req1 = 1'b0;
        tick();
        tests++;
        if (o1 !== 11'b1_0_1101_1_0001) begin
            fails++; $display("FAIL b2b_strobe1 got %b want %b", o1, 11'b1_0_1101_1_0001);
        end
        tick();
        tick();
        tests++;
        if (o1 !== 11'b0_1_1111_1_0000) begin
            fails++; $display("FAIL b2b_done1 got %b want %b", o1, 11'b0_1_1111_1_0000);
        end
        tick();
    endtask

    task automatic test_ext();
        logic [10:0] e_drv, e_stb, e_hld;
`ifdef GPREG_XFER_EXT_EN
        e_drv = 11'b1_0_1111_0_0000;
        e_stb = 11'b1_0_1111_0_0100;
        e_hld = 11'b1_0_1111_0_0000;
`else
        e_drv = 11'b1_0_0111_1_0000;
        e_stb = 11'b1_0_0111_1_0100;
        e_hld = 11'b1_0_0111_1_0000;
`endif
        req1 = 1'b1; SRC = 2'd3; DST = 2'd2; MODE = 1'b1;
        tick();
        req1 = 1'b0;
        tests++;
        if (o1 !== e_drv) begin fails++; $display("FAIL ext_drive got %b want %b", o1, e_drv); end
        tick();
        tests++;
        if (o1 !== e_stb) begin fails++; $display("FAIL ext_strobe got %b want %b", o1, e_stb); end
        tick();
        tests++;
        if (o1 !== e_hld) begin fails++; $display("FAIL ext_hold got %b want %b", o1, e_hld); end
        tick();
        tests++;
        if (o1 !== 11'b0_1_1111_1_0000) begin
            fails++; $display("FAIL ext_done got %b want %b", o1, 11'b0_1_1111_1_0000);
        end
        MODE = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        req1 = 1'b1; SRC = 2'd1; DST = 2'd2; MODE = 1'b0;
        tick();
        req1 = 1'b0;
        tick();
        tests++;
        if (o1 !== 11'b1_0_1101_1_0100) begin
            fails++; $display("FAIL rstmid_strobe got %b want %b", o1, 11'b1_0_1101_1_0100);
        end
        #2;
        RST_bar = 1'b0;
        #1;
        tests++;
        if (o1 !== 11'b0_0_1111_1_0000) begin
            fails++; $display("FAIL rstmid_async got %b want %b", o1, 11'b0_0_1111_1_0000);
        end
        @(negedge CLK);
        RST_bar = 1'b1;
        req1 = 1'b1; SRC = 2'd2; DST = 2'd0;
        tick();
        req1 = 1'b0;
        tick();
        tests++;
        if (o1 !== 11'b1_0_1011_1_0001) begin
            fails++; $display("FAIL rstmid_next_strobe got %b want %b", o1, 11'b1_0_1011_1_0001);
        end
        tick();
        tick();
        tests++;
        if (o1 !== 11'b0_1_1111_1_0000) begin
            fails++; $display("FAIL rstmid_next_done got %b want %b", o1, 11'b0_1_1111_1_0000);
        end
        tick();
    endtask

    task automatic test_capture();
        req1 = 1'b1; SRC = 2'd3; DST = 2'd3; MODE = 1'b0;
        tick();
        req1 = 1'b0; SRC = 2'd0; DST = 2'd1; MODE = 1'b1;
        tests++;
        if (o1 !== 11'b1_0_0111_1_0000) begin
            fails++; $display("FAIL capture_drive got %b want %b", o1, 11'b1_0_0111_1_0000);
        end
        tick();
        tests++;
        if (o1 !== 11'b1_0_0111_1_1000) begin
            fails++; $display("FAIL capture_strobe got %b want %b", o1, 11'b1_0_0111_1_1000);
        end
        tick();
        tests++;
        if (o1 !== 11'b1_0_0111_1_0000) begin
            fails++; $display("FAIL capture_hold got %b want %b", o1, 11'b1_0_0111_1_0000);
        end
        tick();
        tests++;
        if (o1 !== 11'b0_1_1111_1_0000) begin
            fails++; $display("FAIL capture_done got %b want %b", o1, 11'b0_1_1111_1_0000);
        end
        MODE = 1'b0;
        tick();
    endtask

    task automatic test_exclusive();
        tests++;
        if (excl_bad !== 1'b0) begin
            fails++; $display("FAIL bus_exclusive got %b want 0", excl_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold3();
        test_back_to_back();
        test_ext();
        test_reset_mid();
        test_capture();
        tick();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
